// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings and request-field bundle for the instruction/data to
// single-master SRAM-like arbiter.
package sram_like_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_fields_t;

  function automatic owner_t other_side(input owner_t o);
    return (o == OWN_INST) ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like channel: request fields from the master side, handshakes and
// read data back from the slave side.
interface sram_like_arbiter_if;
  import sram_like_arbiter_pkg::*;

  // req is held with stable fields until addr_ok is seen in the same cycle;
  // data_ok marks the single cycle in which rdata is valid for that request.
  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_arbiter_arb2_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that was not granted last.
module arb2_rr
  import sram_like_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output owner_t grant
);

  always_comb begin
    grant = last;
    if (req0 && req1) begin
      grant = other_side(last);
    end else if (req0) begin
      grant = OWN_INST;
    end else if (req1) begin
      grant = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates instruction and data SRAM-like requesters onto one master port,
// with at most one outstanding transaction and a mandatory IDLE between them.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master m,
  output state_t              o_dbg_state,
  output owner_t              o_dbg_owner
);

  state_t      r_state;
  state_t      w_next_state;
  owner_t      r_owner;
  owner_t      r_last_grant;
  owner_t      w_grant;
  req_fields_t r_fields;
  req_fields_t w_sel_fields;
  logic        w_start;
  logic        w_addr_hs;
  logic        w_data_hs;
  logic        w_inst_own;
  logic        w_data_own;

  arb2_rr u_arb2_rr (
    .req0  (inst.req),
    .req1  (data.req),
    .last  (r_last_grant),
    .grant (w_grant)
  );

  assign w_start = (r_state == ST_IDLE) && (inst.req || data.req);

  always_comb begin
    w_sel_fields.wr    = inst.wr;
    w_sel_fields.size  = inst.size;
    w_sel_fields.addr  = inst.addr;
    w_sel_fields.wdata = inst.wdata;
    if (w_grant == OWN_DATA) begin
      w_sel_fields.wr    = data.wr;
      w_sel_fields.size  = data.size;
      w_sel_fields.addr  = data.addr;
      w_sel_fields.wdata = data.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_INST;
      r_last_grant <= OWN_INST;
      r_fields     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_fields     <= w_sel_fields;
      end
    end
  end

  // An address and data handshake in the same ADDR cycle skips DATA entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (inst.req || data.req) w_next_state = ST_ADDR;
      ST_ADDR: if (m.addr_ok) w_next_state = m.data_ok ? ST_IDLE : ST_DATA;
      ST_DATA: if (m.data_ok) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_addr_hs  = (r_state == ST_ADDR) && m.addr_ok;
  assign w_data_hs  = ((r_state == ST_ADDR) && m.addr_ok && m.data_ok) ||
                      ((r_state == ST_DATA) && m.data_ok);
  assign w_inst_own = (r_owner == OWN_INST);
  assign w_data_own = (r_owner == OWN_DATA);

  assign m.req   = (r_state == ST_ADDR);
  assign m.wr    = r_fields.wr;
  assign m.size  = r_fields.size;
  assign m.addr  = r_fields.addr;
  assign m.wdata = r_fields.wdata;

  assign inst.addr_ok = w_addr_hs && w_inst_own;
  assign inst.data_ok = w_data_hs && w_inst_own;
  assign inst.rdata   = m.rdata;
  assign data.addr_ok = w_addr_hs && w_data_own;
  assign data.data_ok = w_data_hs && w_data_own;
  assign data.rdata   = m.rdata;

  assign o_dbg_state = r_state;
  assign o_dbg_owner = r_owner;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench: two requester drivers and a memory responder feed the
// arbiter; a negedge monitor checks every cycle against a transaction model.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  owner_t dbg_owner;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if m_if ();

  sram_like_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst_if),
    .data        (data_if),
    .m           (m_if),
    .o_dbg_state (dbg_state),
    .o_dbg_owner (dbg_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {side, wr, size[1:0], addr[31:0], wdata[31:0]}, side 0 = inst, 1 = data
  logic [67:0] exp_q[$];
  int          total;
  int          bad;

  logic inst_busy, data_busy;
  logic model_last;
  logic resp_phase, resp_hold;
  int   resp_cnt, addr_wait;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C08_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input logic side, input logic wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    if (!side) begin
      inst_if.wr = wr; inst_if.size = sz; inst_if.addr = a; inst_if.wdata = wd;
    end else begin
      data_if.wr = wr; data_if.size = sz; data_if.addr = a; data_if.wdata = wd;
    end
  endtask

  task automatic load_rand(input logic side);
    load(side, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
  endtask

  task automatic push_exp(input logic side);
    if (!side) exp_q.push_back({1'b0, inst_if.wr, inst_if.size, inst_if.addr, inst_if.wdata});
    else       exp_q.push_back({1'b1, data_if.wr, data_if.size, data_if.addr, data_if.wdata});
  endtask

  // Grant order follows from who is asking and who went last.
  task automatic start_round(input logic do_i, input logic do_d);
    logic first;
    if (do_i) begin inst_if.req = 1'b1; inst_busy = 1'b1; end
    if (do_d) begin data_if.req = 1'b1; data_busy = 1'b1; end
    if (do_i && do_d) begin
      first = ~model_last;
      push_exp(first);
      push_exp(~first);
      model_last = ~first;
    end else if (do_i) begin
      push_exp(1'b0);
      model_last = 1'b0;
    end else if (do_d) begin
      push_exp(1'b1);
      model_last = 1'b1;
    end
  endtask

  task automatic respond();
    m_if.addr_ok = 1'b0;
    m_if.data_ok = 1'b0;
    m_if.rdata   = $urandom;
    if (resp_phase) begin
      if (resp_cnt == 0 && !resp_hold) begin
        m_if.data_ok = 1'b1;
        m_if.rdata   = rdata_of(m_if.addr);
        resp_phase   = 1'b0;
      end else begin
        if (resp_cnt > 0) resp_cnt--;
        m_if.addr_ok = ($urandom_range(0, 3) == 0);
      end
    end else if (m_if.req) begin
      if (addr_wait == 0) begin
        m_if.addr_ok = 1'b1;
        if (!resp_hold && $urandom_range(0, 2) == 0) begin
          m_if.data_ok = 1'b1;
          m_if.rdata   = rdata_of(m_if.addr);
        end else begin
          resp_phase = 1'b1;
          resp_cnt   = $urandom_range(0, 3);
        end
      end else begin
        addr_wait--;
        m_if.data_ok = ($urandom_range(0, 2) == 0);
      end
    end else begin
      addr_wait    = $urandom_range(0, 2);
      m_if.addr_ok = ($urandom_range(0, 4) == 0);
      m_if.data_ok = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic step();
    logic s_ia, s_id, s_da, s_dd;
    @(negedge clk);
    s_ia = inst_if.addr_ok; s_id = inst_if.data_ok;
    s_da = data_if.addr_ok; s_dd = data_if.data_ok;
    @(posedge clk);
    #1;
    if (s_ia) begin inst_if.req = 1'b0; inst_if.addr = $urandom; inst_if.wdata = $urandom; end
    if (s_da) begin data_if.req = 1'b0; data_if.addr = $urandom; data_if.wdata = $urandom; end
    if (s_id) inst_busy = 1'b0;
    if (s_dd) data_busy = 1'b0;
    respond();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    inst_if.req = 1'b0; data_if.req = 1'b0;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = '0;
    repeat (n) @(posedge clk);
    #1;
    rst        = 1'b0;
    inst_busy  = 1'b0;
    data_busy  = 1'b0;
    resp_phase = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic wait_round();
    int n;
    n = 0;
    while ((inst_busy || data_busy) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (inst_busy || data_busy) begin
      bad++;
      $display("FAIL round_timeout: busy inst=%0b data=%0b after %0d cycles", inst_busy, data_busy, n);
      exp_q.delete();
      do_reset(2);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          mon_phase;
  logic        mon_after_rst, mon_done;
  logic [67:0] cur;

  always @(negedge clk) begin
    logic       hs_data;
    logic [3:0] exp_ok, act_ok;
    if (rst) begin
      mon_phase     = 0;
      mon_after_rst = 1'b1;
      mon_done      = 1'b0;
    end else begin
      if (mon_after_rst) begin
        check("rst_m_req",   32'(m_if.req),   32'd0);
        check("rst_m_wr",    32'(m_if.wr),    32'd0);
        check("rst_m_size",  32'(m_if.size),  32'd0);
        check("rst_m_addr",  m_if.addr,       32'd0);
        check("rst_m_wdata", m_if.wdata,      32'd0);
        check("rst_state",   32'(dbg_state),  32'(ST_IDLE));
        check("rst_owner",   32'(dbg_owner),  32'(OWN_INST));
        mon_after_rst = 1'b0;
      end
      if (mon_done) begin
        check("turnaround_idle", 32'(m_if.req), 32'd0);
        mon_done = 1'b0;
      end else if (mon_phase == 0 && m_if.req) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: m_addr=%h with empty queue", m_if.addr);
        end else begin
          cur       = exp_q.pop_front();
          mon_phase = 1;
        end
      end
      check("m_req", 32'(m_if.req), 32'(mon_phase == 1));
      if (mon_phase == 1) begin
        check("m_wr",    32'(m_if.wr),   32'(cur[66]));
        check("m_size",  32'(m_if.size), 32'(cur[65:64]));
        check("m_addr",  m_if.addr,      cur[63:32]);
        check("m_wdata", m_if.wdata,     cur[31:0]);
      end
      hs_data = ((mon_phase == 1) && m_if.addr_ok && m_if.data_ok) ||
                ((mon_phase == 2) && m_if.data_ok);
      exp_ok = {(mon_phase == 1) && m_if.addr_ok && !cur[67], hs_data && !cur[67],
                (mon_phase == 1) && m_if.addr_ok &&  cur[67], hs_data &&  cur[67]};
      act_ok = {inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok};
      check("ok_vec_ia_id_da_dd", 32'(act_ok), 32'(exp_ok));
      if (hs_data) begin
        check("inst_rdata", inst_if.rdata, rdata_of(cur[63:32]));
        check("data_rdata", data_if.rdata, rdata_of(cur[63:32]));
        mon_done = 1'b1;
      end
      if (mon_phase == 1 && m_if.addr_ok) mon_phase = m_if.data_ok ? 0 : 2;
      else if (mon_phase == 2 && m_if.data_ok) mon_phase = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] pick;
    total = 0; bad = 0;
    rst = 1'b1;
    inst_busy = 1'b0; data_busy = 1'b0; model_last = 1'b0;
    resp_phase = 1'b0; resp_hold = 1'b0; resp_cnt = 0; addr_wait = 0;
    mon_phase = 0; mon_after_rst = 1'b0; mon_done = 1'b0; cur = '0;
    load(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    load(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    do_reset(3);

    // contention straight out of reset: data write goes first
    load(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
    load(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF);
    start_round(1'b1, 1'b1);
    wait_round();

    load(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
    start_round(1'b1, 1'b0);
    wait_round();

    repeat (2) begin
      load_rand(1'b0); load_rand(1'b1);
      start_round(1'b1, 1'b1);
      wait_round();
    end

    // requester lets go right after the grant and scribbles its address
    repeat (4) begin
      load_rand(1'b0);
      start_round(1'b1, 1'b0);
      step();
      inst_if.req = 1'b0;
      inst_if.addr = 32'd0;
      wait_round();
    end

    repeat (120) begin
      pick = 2'($urandom_range(1, 3));
      load_rand(1'b0); load_rand(1'b1);
      start_round(pick[0], pick[1]);
      if (pick != 2'b11 && $urandom_range(0, 3) == 0) begin
        step();
        if (pick[0]) begin inst_if.req = 1'b0; inst_if.addr = $urandom; end
        else         begin data_if.req = 1'b0; data_if.addr = $urandom; end
      end
      wait_round();
    end

    // reset while waiting in DATA, then a stray data_ok in IDLE
    resp_hold = 1'b1;
    load_rand(1'b0);
    start_round(1'b1, 1'b0);
    repeat (6) step();
    do_reset(1);
    resp_hold = 1'b0;
    m_if.addr_ok = 1'b1;
    m_if.data_ok = 1'b1;
    step();
    load_rand(1'b0); load_rand(1'b1);
    start_round(1'b1, 1'b1);
    wait_round();

    repeat (3) step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("final_phase_idle", 32'(mon_phase), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
